// File: rtl/factorial_ctrl_if.sv
// Start/operand request and result/status bundle for the factorial controller.
// The master issues requests; the slave (the controller) returns status and result.
interface factorial_ctrl_if;
  localparam int unsigned N_W   = 4;
  localparam int unsigned RES_W = 32;

  logic             start;
  logic [N_W-1:0]   n;
  logic             busy;
  logic             done;
  logic             err;
  logic [RES_W-1:0] result;

  modport master (output start, n, input busy, done, err, result);
  modport slave  (input start, n, output busy, done, err, result);
endinterface

// File: rtl/factorial_ctrl.sv
// N! for a 4-bit operand using a repeated shift-add multiply.
// The adder is a ripple chain of 4-bit carry-lookahead slices.
module cla4_ov (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ c;
  end
endmodule

module factorial_ctrl (
  input  logic             clk,
  input  logic             reset_n,
  factorial_ctrl_if.slave  bus
);
  localparam int unsigned N_W    = 4;
  localparam int unsigned RES_W  = 32;
  localparam int unsigned SLICES = RES_W / 4;

  typedef enum logic [1:0] {IDLE, MUL, NEXT, DONE} state_e;

  state_e           state_q, state_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [RES_W-1:0] prod_q, prod_d;
  logic [N_W-1:0]   k_q, k_d;
  logic [1:0]       bi_q, bi_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [RES_W-1:0] result_q, result_d;

  logic [RES_W-1:0] add_b;
  logic [RES_W-1:0] add_s;
  logic [SLICES:0]  add_c;

  // prod + (acc << bi) through the chained slices
  assign add_b    = RES_W'(acc_q << bi_q);
  assign add_c[0] = 1'b0;

  for (genvar i = 0; i < SLICES; i++) begin : g_cla
    cla4_ov u_slice (
      .a  (prod_q[4*i +: 4]),
      .b  (add_b[4*i +: 4]),
      .ci (add_c[i]),
      .s  (add_s[4*i +: 4]),
      .co (add_c[i+1])
    );
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    k_d      = k_q;
    bi_d     = bi_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    result_d = result_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          ovf_d = 1'b0;
          err_d = 1'b0;
          if (bus.n > N_W'(12)) begin
            result_d = '0;
            err_d    = 1'b1;
            done_d   = 1'b1;
            state_d  = DONE;
          end else if (bus.n <= N_W'(1)) begin
            acc_d    = RES_W'(1);
            result_d = RES_W'(1);
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            acc_d   = RES_W'(1);
            k_d     = bus.n;
            prod_d  = '0;
            bi_d    = 2'd0;
            busy_d  = 1'b1;
            state_d = MUL;
          end
        end
      end
      MUL: begin
        busy_d = 1'b1;
        if (k_q[bi_q]) begin
          prod_d = add_s;
          if (add_c[SLICES]) ovf_d = 1'b1;
        end
        bi_d = 2'(bi_q + 2'd1);
        if (bi_q == 2'd3) state_d = NEXT;
      end
      NEXT: begin
        acc_d  = prod_q;
        prod_d = '0;
        k_d    = N_W'(k_q - N_W'(1));
        bi_d   = 2'd0;
        // last multiplier was 2: result is final, publish it on entry to DONE
        if (k_q == N_W'(2)) begin
          err_d    = err_q | ovf_q;
          result_d = (err_q | ovf_q) ? '0 : prod_q;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          busy_d  = 1'b1;
          state_d = MUL;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      prod_q   <= '0;
      k_q      <= '0;
      bi_q     <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      k_q      <= k_d;
      bi_q     <= bi_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_factorial_ctrl.sv
// Randomized bench for factorial_ctrl against a timeline-level reference model.
module tb_factorial_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  factorial_ctrl_if bus();
  factorial_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // reference model state: what the outputs must be after each edge
  bit          m_busy, m_done, m_err, m_infl, m_cool, m_perr;
  logic [31:0] m_res, m_pres;
  int          m_left, m_v;

  function automatic logic [31:0] fact(input int v);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 2; i <= v; i++) r = r * 32'(i);
    return r;
  endfunction

  function automatic int exp_lat(input int v);
    return (v < 2 || v > 12) ? 1 : 5 * (v - 1) + 1;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_done = 0; m_err = 0; m_res = '0;
      m_infl = 0; m_cool = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_infl) begin
        m_left--;
        if (m_left == 0) begin
          m_infl = 0; m_busy = 0; m_done = 1; m_cool = 1;
          m_res  = m_pres; m_err = m_perr;
        end
      end else if (m_cool) begin
        m_cool = 0;
      end else if (bus.start === 1'b1) begin
        m_v   = int'(bus.n);
        m_err = 0;
        if (m_v > 12) begin
          m_res = '0; m_err = 1; m_done = 1; m_cool = 1;
        end else if (m_v < 2) begin
          m_res = 32'd1; m_done = 1; m_cool = 1;
        end else begin
          m_pres = fact(m_v); m_perr = 0;
          m_infl = 1; m_busy = 1; m_left = 5 * (m_v - 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",   32'(bus.busy), 32'(m_busy));
      chk("done",   32'(bus.done), 32'(m_done));
      chk("result", bus.result,    m_res);
      chk("err",    32'(bus.err),  32'(m_err));
    end
  end

  task automatic run_op(input logic [3:0] nv, input bit b2b, output logic [31:0] res_o);
    int lat;
    bit seen;
    res_o = 'x;
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = nv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.n     = 4'($urandom);
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat <= 80) begin
      if (bus.done === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout n=%0d: no done within 80 cycles", nv);
    end else begin
      chk("latency", 32'(lat), 32'(exp_lat(int'(nv))));
      chk("err_at_done", 32'(bus.err), (nv > 4'd12) ? 32'd1 : 32'd0);
      chk("result_at_done", bus.result, (nv > 4'd12) ? 32'd0 : fact(int'(nv)));
      res_o = bus.result;
      if (b2b) begin
        bus.start = 1'b1;
        bus.n     = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_ignored_busy", 32'(bus.busy), 32'd0);
      end
    end
  endtask

  initial begin
    logic [31:0] r;
    int lat;
    bit seen;
    bus.start = 1'b0;
    bus.n     = 4'd0;
    reset_n   = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk("reset_result", bus.result, 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_err", 32'(bus.err), 32'd0);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_op(4'd0, 1'b0, r);  chk("n0_literal", r, 32'd1);
    run_op(4'd1, 1'b0, r);  chk("n1_literal", r, 32'd1);
    run_op(4'd5, 1'b0, r);  chk("n5_literal", r, 32'd120);
    run_op(4'd12, 1'b0, r); chk("n12_literal", r, 32'h1C8CFC00);
    for (int i = 2; i <= 11; i++) run_op(4'(i), 1'b0, r);
    run_op(4'd13, 1'b0, r); chk("n13_literal", r, 32'd0);
    run_op(4'd15, 1'b0, r); chk("n15_err_literal", 32'(bus.err), 32'd1);
    run_op(4'd3, 1'b0, r);  chk("n3_literal", r, 32'd6);
    chk("n3_err_cleared", 32'(bus.err), 32'd0);

    // second start during a run must be dropped
    @(negedge clk);
    bus.start = 1'b1; bus.n = 4'd7;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1; seen = 1'b0;
    while (!seen && lat <= 80) begin
      if (bus.done === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
        if (lat == 10) begin bus.start = 1'b1; bus.n = 4'd3; end
        else bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk("overlap_latency", 32'(lat), 32'd31);
    chk("overlap_literal", bus.result, 32'd5040);

    // reset in the middle of a run discards it
    @(negedge clk);
    bus.start = 1'b1; bus.n = 4'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (16) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    run_op(4'd4, 1'b0, r);  chk("n4_after_reset", r, 32'd24);

    run_op(4'd6, 1'b1, r);  chk("n6_literal", r, 32'd720);
    run_op(4'd14, 1'b1, r);

    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), r);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
